// File: rtl/prog_launcher.sv
// Host-side sequencer for the processor Start/Ack run protocol: launches each
// program in turn, times its run, and reports one result record per program.
module prog_launcher #(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 16'hFFFF,
    parameter int unsigned PROG_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    output logic              Start,
    input  logic              Ack,
    output logic              Busy,
    output logic              ResValid,
    input  logic              ResReady,
    output logic [PROG_W-1:0] ResProg,
    output logic [CNT_W-1:0]  ResCycles,
    output logic              ResTimeout,
    output logic              Done,
    output logic              Err
);

    localparam int unsigned LC_W = $clog2(START_CYC + 1);
    localparam logic [LC_W-1:0]   LC_LAST   = LC_W'(START_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_TMO   = CNT_W'(TIMEOUT);
    localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(NUM_PROGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        REPORT,
        FINISH
    } stateT;

    stateT             state, stateNext;
    logic [LC_W-1:0]   launchCnt, launchCntNext;
    logic [CNT_W-1:0]  runCnt, runCntNext;
    logic [PROG_W-1:0] progNext;
    logic [CNT_W-1:0]  cyclesNext;
    logic              timeoutNext;
    logic              errNext;
    logic              startNext;

    // State and datapath registers; the status outputs follow the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            launchCnt  <= '0;
            runCnt     <= '0;
            Start      <= 1'b0;
            Busy       <= 1'b0;
            ResValid   <= 1'b0;
            ResProg    <= '0;
            ResCycles  <= '0;
            ResTimeout <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            state      <= stateNext;
            launchCnt  <= launchCntNext;
            runCnt     <= runCntNext;
            Start      <= startNext;
            Busy       <= (stateNext == LAUNCH) || (stateNext == RUN) || (stateNext == REPORT);
            ResValid   <= (stateNext == REPORT);
            ResProg    <= progNext;
            ResCycles  <= cyclesNext;
            ResTimeout <= timeoutNext;
            Done       <= (stateNext == FINISH);
            Err        <= errNext;
        end
    end

    // Next-state and next-value logic.
    always_comb begin
        stateNext     = state;
        launchCntNext = launchCnt;
        runCntNext    = runCnt;
        progNext      = ResProg;
        cyclesNext    = ResCycles;
        timeoutNext   = ResTimeout;
        errNext       = Err;
        // The first LAUNCH cycle keeps Start low, then Start is held START_CYC cycles.
        startNext     = (state == LAUNCH) && (launchCnt != LC_LAST);

        case (state)
            IDLE, FINISH: begin
                if (Go) begin
                    stateNext     = LAUNCH;
                    launchCntNext = '0;
                    progNext      = '0;
                    errNext       = 1'b0;
                end
            end
            LAUNCH: begin
                if (launchCnt == LC_LAST) begin
                    stateNext  = RUN;
                    runCntNext = '0;
                end else begin
                    launchCntNext = launchCnt + LC_W'(1);
                end
            end
            RUN: begin
                if (Ack) begin
                    cyclesNext  = runCnt;
                    timeoutNext = 1'b0;
                    stateNext   = REPORT;
                end else if (runCnt == CNT_LAST) begin
                    cyclesNext  = CNT_TMO;
                    timeoutNext = 1'b1;
                    stateNext   = REPORT;
                end else begin
                    runCntNext = runCnt + CNT_W'(1);
                end
            end
            REPORT: begin
                if (ResReady) begin
                    if (ResTimeout) begin
                        stateNext = FINISH;
                        errNext   = 1'b1;
                    end else if (ResProg == PROG_LAST) begin
                        stateNext = FINISH;
                    end else begin
                        progNext      = ResProg + PROG_W'(1);
                        launchCntNext = '0;
                        stateNext     = LAUNCH;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_launcher.sv
// Randomized/directed bench for prog_launcher with a behavioural processor
// and an expected-record model derived from latency and timeout budget.
module tb_prog_launcher;

    localparam int unsigned NP  = 3;
    localparam int unsigned SC  = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned TO  = 30;
    localparam int unsigned TO2 = 1;
    localparam int unsigned PW  = 2;

    logic          Clk = 1'b0;
    logic          Reset, Go, Ack, ResReady;
    logic          Start, Busy, ResValid, ResTimeout, Done, Err;
    logic [PW-1:0] ResProg;
    logic [CW-1:0] ResCycles;

    logic          go2, ack2, ready2;
    logic          start2, busy2, resValid2, resTimeout2, done2, err2;
    logic [PW-1:0] resProg2;
    logic [CW-1:0] resCycles2;

    int nPass   = 0;
    int nChecks = 0;
    int lats[NP];
    int dlys[NP];

    always #5 Clk = ~Clk;

    prog_launcher #(.NUM_PROGS(NP), .START_CYC(SC), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Start(Start), .Ack(Ack), .Busy(Busy),
        .ResValid(ResValid), .ResReady(ResReady), .ResProg(ResProg),
        .ResCycles(ResCycles), .ResTimeout(ResTimeout), .Done(Done), .Err(Err)
    );

    prog_launcher #(.NUM_PROGS(NP), .START_CYC(SC), .CNT_W(CW), .TIMEOUT(TO2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Go(go2), .Start(start2), .Ack(ack2), .Busy(busy2),
        .ResValid(resValid2), .ResReady(ready2), .ResProg(resProg2),
        .ResCycles(resCycles2), .ResTimeout(resTimeout2), .Done(done2), .Err(err2)
    );

    // Expected record for a program whose processor acks after lat low cycles.
    function automatic int expCycles(input int lat, input int to);
        return (lat < to) ? lat : to;
    endfunction

    function automatic bit expTmo(input int lat, input int to);
        return lat >= to;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Waits through a launch of the main DUT; returns at the first RUN-cycle negedge.
    task automatic waitLaunch();
        int i;
        int hi;
        i = 0;
        while (Start !== 1'b1 && i < 10) begin @(negedge Clk); i++; end
        chk("start_rise", Start, 1);
        hi = 0;
        while (Start === 1'b1 && hi < 10) begin @(negedge Clk); hi++; end
        chk("start_len", hi, SC);
    endtask

    task automatic runProg(input int lat, input int dly, input int prog, input bit last,
                           output bit stop);
        int i;
        int cyc;
        bit tmo;
        cyc = expCycles(lat, TO);
        tmo = expTmo(lat, TO);
        waitLaunch();
        i = 0;
        Ack = (lat == 0);
        ResReady = 1'($urandom % 2);
        Go = 1'($urandom % 2);
        @(negedge Clk);
        while (ResValid !== 1'b1 && i < int'(TO) + 5) begin
            i++;
            Ack = (i == lat);
            ResReady = 1'($urandom % 2);
            Go = 1'($urandom % 2);
            @(negedge Clk);
        end
        Ack = 1'b0;
        Go = 1'b0;
        ResReady = 1'b0;
        chk("rec_valid", ResValid, 1);
        chk("rec_prog", ResProg, prog);
        chk("rec_cycles", ResCycles, cyc);
        chk("rec_tmo", ResTimeout, tmo);
        chk("rec_busy", Busy, 1);
        for (int d = 0; d < dly; d++) begin
            @(negedge Clk);
            chk("bp_valid", ResValid, 1);
            chk("bp_cycles", ResCycles, cyc);
            chk("bp_start", Start, 0);
        end
        ResReady = 1'b1;
        @(negedge Clk);
        ResReady = 1'b0;
        chk("hs_valid_drop", ResValid, 0);
        chk("hs_start_low", Start, 0);
        stop = tmo || last;
        if (stop) begin
            chk("fin_done", Done, 1);
            chk("fin_err", Err, tmo);
            chk("fin_busy", Busy, 0);
        end else begin
            chk("next_busy", Busy, 1);
            chk("next_done", Done, 0);
        end
    endtask

    task automatic runCampaign();
        bit stop;
        int p;
        int highs;
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        chk("go_busy", Busy, 1);
        chk("go_done", Done, 0);
        chk("go_err", Err, 0);
        chk("go_start", Start, 0);
        stop = 1'b0;
        p = 0;
        while (!stop) begin
            runProg(lats[p], dlys[p], p, (p == int'(NP) - 1), stop);
            p++;
        end
        if (p < int'(NP)) begin
            highs = 0;
            repeat (8) begin
                @(negedge Clk);
                if (Start === 1'b1) highs++;
            end
            chk("no_launch_after_tmo", highs, 0);
            chk("done_held", Done, 1);
        end
    endtask

    initial begin
        int i;
        Reset = 1'b1; Go = 1'b0; Ack = 1'b0; ResReady = 1'b0;
        go2 = 1'b0; ack2 = 1'b0; ready2 = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_start", Start, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_valid", ResValid, 0);
        chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        chk("rst_cycles", ResCycles, 0);
        chk("rst2_start", start2, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // TIMEOUT=1: ack on first RUN cycle wins, then a silent program times out.
        go2 = 1'b1;
        @(negedge Clk);
        go2 = 1'b0;
        chk("t1_busy", busy2, 1);
        i = 0;
        while (start2 !== 1'b1 && i < 10) begin @(negedge Clk); i++; end
        while (start2 === 1'b1 && i < 20) begin @(negedge Clk); i++; end
        ack2 = 1'b1;
        @(negedge Clk);
        ack2 = 1'b0;
        chk("t1_valid", resValid2, 1);
        chk("t1_cycles", resCycles2, expCycles(0, TO2));
        chk("t1_tmo", resTimeout2, expTmo(0, TO2));
        ready2 = 1'b1;
        @(negedge Clk);
        ready2 = 1'b0;
        i = 0;
        while (resValid2 !== 1'b1 && i < 20) begin @(negedge Clk); i++; end
        chk("t1b_prog", resProg2, 1);
        chk("t1b_cycles", resCycles2, expCycles(1000, TO2));
        chk("t1b_tmo", resTimeout2, expTmo(1000, TO2));
        ready2 = 1'b1;
        @(negedge Clk);
        ready2 = 1'b0;
        chk("t1_done", done2, 1);
        chk("t1_err", err2, 1);

        // Nominal campaign.
        lats = '{10, 25, 4};
        dlys = '{0, 0, 0};
        runCampaign();

        // Backpressure in REPORT.
        lats = '{int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), int'($urandom_range(0, 20))};
        dlys = '{5, 0, 3};
        runCampaign();

        // Program 1 never acks.
        lats = '{5, 1000, 3};
        dlys = '{0, 2, 0};
        runCampaign();

        // Restart from FINISH with Err set; immediate ack on program 0.
        lats = '{0, int'($urandom_range(0, 20)), int'($urandom_range(0, 20))};
        dlys = '{1, 0, 0};
        runCampaign();

        // Reset mid-RUN.
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        waitLaunch();
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("rrun_start", Start, 0);
        chk("rrun_valid", ResValid, 0);
        chk("rrun_busy", Busy, 0);
        chk("rrun_done", Done, 0);

        // Reset mid-REPORT with the record pending.
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        waitLaunch();
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk("rrep_pending", ResValid, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("rrep_start", Start, 0);
        chk("rrep_valid", ResValid, 0);
        chk("rrep_busy", Busy, 0);
        chk("rrep_done", Done, 0);

        // Random campaigns after reset restart at program 0.
        repeat (4) begin
            for (int p = 0; p < int'(NP); p++) begin
                lats[p] = int'($urandom_range(0, 35));
                dlys[p] = int'($urandom_range(0, 3));
            end
            runCampaign();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
